// File: rtl/tracker_calib_pkg.sv
// Shared types and constants for the tracker auto-calibration sequencer.
// Contents: FSM state encoding, sample width, signed sample limits and a
// saturation helper used when deriving thresholds.
package tracker_calib_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SMIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SAMPLE_W-1:0] SMAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    COMPUTE = 3'd2,
    APPLY   = 3'd3,
    RUN     = 3'd4
  } calib_state_t;

  // Clamp a two-guard-bit result back into the signed sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(
    input logic signed [SAMPLE_W+1:0] v
  );
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/signed_minmax_acc.sv
// Running signed minimum/maximum accumulator.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset (same state as clear)
//   clear   - restart accumulation: min <- SMAX, max <- SMIN
//   en      - fold 'sample' into the running min/max
//   sample  - signed input sample
//   min_val - registered running minimum
//   max_val - registered running maximum
module signed_minmax_acc
  import tracker_calib_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic signed [SAMPLE_W-1:0] min_val,
  output logic signed [SAMPLE_W-1:0] max_val
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min_val <= SMAX;
      max_val <= SMIN;
    end else if (en) begin
      if (sample < min_val) min_val <= sample;
      if (sample > max_val) max_val <= sample;
    end
  end

endmodule

// File: rtl/axis_tracker_calibrator.sv
// Auto-calibration sequencer for the quadrature position tracker.
// Measures min/max of channel A over 2^log_window accepted beats, derives
// hysteresis thresholds around the signal centre, loads them into the
// tracker and then releases the tracker from reset.
// Ports:
//   aclk, areset          - clock, synchronous active-high reset
//   start, abort          - single-cycle control pulses (abort wins)
//   log_window            - window = 2^min(log_window, MAX_LOG_WINDOW) beats
//   hyst_shift            - half-band = span >> hyst_shift (0 acts as 1)
//   min_span              - minimum acceptable max-min (unsigned)
//   S_AXIS_tvalid/tdata   - sample stream {chan B, chan A}
//   S_AXIS_tready         - always ready outside reset
//   lower/upper_threshold - signed thresholds to the tracker
//   tracker_aresetn       - active-low tracker reset, high only in RUN
//   busy, done, fail      - status (done is a one-cycle pulse, fail a level)
//   sample_min/max        - last captured channel A extremes
module axis_tracker_calibrator #(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG_WINDOW     = 20,
  parameter logic signed [S_AXIS_TDATA_WIDTH/2-1:0] DEFAULT_LOWER = -16'sd1024,
  parameter logic signed [S_AXIS_TDATA_WIDTH/2-1:0] DEFAULT_UPPER = 16'sd1024
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [4:0]                           log_window,
  input  logic [3:0]                           hyst_shift,
  input  logic [15:0]                          min_span,
  input  logic                                 S_AXIS_tvalid,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]        S_AXIS_tdata,
  output logic                                 S_AXIS_tready,
  output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
  output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
  output logic                                 tracker_aresetn,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 fail,
  output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] sample_min,
  output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] sample_max
);
  import tracker_calib_pkg::*;

  localparam logic [4:0]                CLAMP_LW = 5'(MAX_LOG_WINDOW);
  localparam logic [MAX_LOG_WINDOW:0]   CNT_ONE  = {{MAX_LOG_WINDOW{1'b0}}, 1'b1};

  calib_state_t                 state;
  logic [4:0]                   window_r;
  logic [MAX_LOG_WINDOW:0]      beat_count;
  logic [SAMPLE_W:0]            span_r;
  logic signed [SAMPLE_W-1:0]   center_r;

  logic                         beat;
  logic                         acc_clear;
  logic                         acc_en;
  logic signed [SAMPLE_W-1:0]   chan_a;
  logic signed [SAMPLE_W-1:0]   acc_min;
  logic signed [SAMPLE_W-1:0]   acc_max;
  logic [MAX_LOG_WINDOW:0]      count_inc;
  logic [MAX_LOG_WINDOW:0]      beat_target;
  logic [SAMPLE_W:0]            span_c;
  logic [SAMPLE_W:0]            sum_c;
  logic [3:0]                   eff_shift;
  logic [SAMPLE_W:0]            half;
  logic signed [SAMPLE_W+1:0]   lower_c;
  logic signed [SAMPLE_W+1:0]   upper_c;
  logic                         unused_chan_b;

  assign S_AXIS_tready = ~areset;
  assign beat          = S_AXIS_tvalid & S_AXIS_tready;
  assign chan_a        = S_AXIS_tdata[SAMPLE_W-1:0];
  // Channel B is carried on the same beat but plays no part in calibration.
  assign unused_chan_b = ^S_AXIS_tdata[S_AXIS_TDATA_WIDTH-1:SAMPLE_W];

  always_comb begin
    acc_clear   = ((state == IDLE) || (state == RUN)) && start && !abort;
    acc_en      = (state == ACQUIRE) && beat && !abort;
    count_inc   = beat_count + CNT_ONE;
    beat_target = CNT_ONE << window_r;
    // Both are 17-bit so neither the difference nor the sum can overflow.
    span_c      = {acc_max[SAMPLE_W-1], acc_max} - {acc_min[SAMPLE_W-1], acc_min};
    sum_c       = {acc_max[SAMPLE_W-1], acc_max} + {acc_min[SAMPLE_W-1], acc_min};
    eff_shift   = (hyst_shift == 4'd0) ? 4'd1 : hyst_shift;
    half        = span_r >> eff_shift;
    lower_c     = {{2{center_r[SAMPLE_W-1]}}, center_r} - {1'b0, half};
    upper_c     = {{2{center_r[SAMPLE_W-1]}}, center_r} + {1'b0, half};
  end

  signed_minmax_acc u_minmax (
    .clk     (aclk),
    .rst     (areset),
    .clear   (acc_clear),
    .en      (acc_en),
    .sample  (chan_a),
    .min_val (acc_min),
    .max_val (acc_max)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state           <= IDLE;
      window_r        <= '0;
      beat_count      <= '0;
      span_r          <= '0;
      center_r        <= '0;
      lower_threshold <= DEFAULT_LOWER;
      upper_threshold <= DEFAULT_UPPER;
      tracker_aresetn <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fail            <= 1'b0;
      sample_min      <= '0;
      sample_max      <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state           <= IDLE;
        busy            <= 1'b0;
        tracker_aresetn <= 1'b0;
      end else begin
        case (state)
          IDLE, RUN: begin
            if (start) begin
              state           <= ACQUIRE;
              beat_count      <= '0;
              fail            <= 1'b0;
              window_r        <= (log_window > CLAMP_LW) ? CLAMP_LW : log_window;
              busy            <= 1'b1;
              tracker_aresetn <= 1'b0;
            end
          end
          ACQUIRE: begin
            if (beat) begin
              beat_count <= count_inc;
              // The accumulator folds this same beat in at this edge.
              if (count_inc == beat_target) state <= COMPUTE;
            end
          end
          COMPUTE: begin
            sample_min <= acc_min;
            sample_max <= acc_max;
            span_r     <= span_c;
            center_r   <= sum_c[SAMPLE_W:1];
            state      <= APPLY;
          end
          APPLY: begin
            busy <= 1'b0;
            if (span_r >= {1'b0, min_span}) begin
              lower_threshold <= sat_sample(lower_c);
              upper_threshold <= sat_sample(upper_c);
              done            <= 1'b1;
              tracker_aresetn <= 1'b1;
              state           <= RUN;
            end else begin
              fail  <= 1'b1;
              state <= IDLE;
            end
          end
          default: begin
            state           <= IDLE;
            busy            <= 1'b0;
            tracker_aresetn <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_tracker_calibrator.sv
// Self-checking bench for axis_tracker_calibrator: directed scenarios plus
// randomized calibration runs compared against an arithmetic reference.
module tb_axis_tracker_calibrator;

  logic               aclk = 1'b0;
  logic               areset = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [4:0]         log_window = '0;
  logic [3:0]         hyst_shift = '0;
  logic [15:0]        min_span = '0;
  logic               tvalid = 1'b0;
  logic [31:0]        tdata = '0;
  logic               tready;
  logic signed [15:0] lower_threshold, upper_threshold;
  logic signed [15:0] sample_min, sample_max;
  logic               tracker_aresetn, busy, done, fail;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int m_lo = -1024, m_hi = 1024, m_smin = 0, m_smax = 0;
  int data_q[$];
  int gap_q[$];

  always #5 aclk = ~aclk;

  axis_tracker_calibrator #(
    .S_AXIS_TDATA_WIDTH (32),
    .MAX_LOG_WINDOW     (20),
    .DEFAULT_LOWER      (-16'sd1024),
    .DEFAULT_UPPER      (16'sd1024)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .start           (start),
    .abort           (abort),
    .log_window      (log_window),
    .hyst_shift      (hyst_shift),
    .min_span        (min_span),
    .S_AXIS_tvalid   (tvalid),
    .S_AXIS_tdata    (tdata),
    .S_AXIS_tready   (tready),
    .lower_threshold (lower_threshold),
    .upper_threshold (upper_threshold),
    .tracker_aresetn (tracker_aresetn),
    .busy            (busy),
    .done            (done),
    .fail            (fail),
    .sample_min      (sample_min),
    .sample_max      (sample_max)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_thresholds(input string tag);
    chk({tag, "_lo"}, lower_threshold, m_lo);
    chk({tag, "_hi"}, upper_threshold, m_hi);
  endtask

  task automatic chk_samples(input string tag);
    chk({tag, "_smin"}, sample_min, m_smin);
    chk({tag, "_smax"}, sample_max, m_smax);
  endtask

  // One calibration attempt. abort_at >= 0 aborts before that beat index.
  task automatic run_cal(input int lw, input int hs, input int ms, input int abort_at);
    int win, n, mn, mx, span, ctr, half, sh, lo, hi, smp, g;
    win = (lw > 20) ? 20 : lw;
    n   = 1 << win;
    while (data_q.size() < n) data_q.push_back(int'($urandom_range(0, 65535)) - 32768);
    log_window = 5'(lw);
    hyst_shift = 4'(hs);
    min_span   = 16'(ms);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_fail", fail, 0);
    chk("start_trk", tracker_aresetn, 0);
    mn = 32767;
    mx = -32768;
    for (int i = 0; i < n; i++) begin
      g = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
      repeat (g) begin
        tvalid = 1'b0;
        tdata  = $urandom;
        tick;
        chk("gap_busy", busy, 1);
      end
      if (i == abort_at) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_trk", tracker_aresetn, 0);
        chk("abort_done", done, 0);
        chk_thresholds("abort");
        chk_samples("abort");
        data_q.delete();
        gap_q.delete();
        return;
      end
      smp    = data_q.pop_front();
      tvalid = 1'b1;
      tdata  = {16'($urandom), 16'(smp)};
      start  = (i == 1);   // start while busy must not restart the window
      tick;
      tvalid = 1'b0;
      start  = 1'b0;
      if (smp < mn) mn = smp;
      if (smp > mx) mx = smp;
      chk("acq_busy", busy, 1);
      chk("acq_trk", tracker_aresetn, 0);
    end
    // Now in COMPUTE
    chk("cmp_done", done, 0);
    tick;
    // Now in APPLY: extremes visible, thresholds not yet changed
    m_smin = mn;
    m_smax = mx;
    chk_samples("apply");
    chk("apply_busy", busy, 1);
    chk("apply_trk", tracker_aresetn, 0);
    chk_thresholds("apply_hold");
    span = mx - mn;
    ctr  = (mx + mn) >>> 1;
    sh   = (hs == 0) ? 1 : hs;
    half = span >> sh;
    lo   = ctr - half;
    hi   = ctr + half;
    if (lo < -32768) lo = -32768;
    if (hi > 32767) hi = 32767;
    tick;
    chk("res_busy", busy, 0);
    if (span >= ms) begin
      m_lo = lo;
      m_hi = hi;
      chk("res_done", done, 1);
      chk("res_trk", tracker_aresetn, 1);
      chk("res_fail", fail, 0);
    end else begin
      chk("res_done", done, 0);
      chk("res_trk", tracker_aresetn, 0);
      chk("res_fail", fail, 1);
    end
    chk_thresholds("res");
    tick;
    chk("post_done", done, 0);
    chk("post_trk", tracker_aresetn, (span >= ms) ? 1 : 0);
  endtask

  initial begin
    int lw, hs, ms, ab, n;

    // Reset state
    tick;
    chk("rst_tready", tready, 0);
    chk_thresholds("rst");
    chk_samples("rst");
    chk("rst_trk", tracker_aresetn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    areset = 1'b0;
    #1;
    chk("tready", tready, 1);
    tick;

    // Span too small: defaults retained
    data_q = '{100, -200, 300, 0};
    run_cal(2, 2, 1000, -1);
    chk("fail_lo_const", lower_threshold, -1024);
    chk("fail_hi_const", upper_threshold, 1024);

    // Nominal
    data_q = '{100, -200, 300, 0};
    run_cal(2, 2, 100, -1);
    chk("nom_lo_const", lower_threshold, -75);
    chk("nom_hi_const", upper_threshold, 175);

    // start+abort together from RUN: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("coll_busy", busy, 0);
    chk("coll_trk", tracker_aresetn, 0);
    chk_thresholds("coll");
    tick;
    chk("coll_idle", busy, 0);

    // Full-range extremes
    data_q = '{-32768, 32767};
    run_cal(1, 1, 0, -1);
    chk("ext_lo_const", lower_threshold, -32768);
    chk("ext_hi_const", upper_threshold, 32766);

    // Gaps in tvalid: 1,0,0,1,0,1,1
    data_q = '{-50, 400, 20, -10};
    gap_q  = '{0, 2, 1, 0};
    run_cal(2, 3, 10, -1);

    // Abort after 2 of 4 beats
    run_cal(2, 2, 0, 2);

    // Single-beat window
    data_q = '{5};
    run_cal(0, 0, 0, -1);

    // areset after 3 beats of an 8-beat window, with calibrated thresholds
    log_window = 5'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) begin
      tvalid = 1'b1;
      tdata  = $urandom;
      tick;
    end
    tvalid = 1'b0;
    areset = 1'b1;
    tick;
    areset = 1'b0;
    m_lo = -1024;
    m_hi = 1024;
    m_smin = 0;
    m_smax = 0;
    chk_thresholds("mrst");
    chk_samples("mrst");
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_fail", fail, 0);
    chk("mrst_trk", tracker_aresetn, 0);
    tick;
    run_cal(3, 4, 50, -1);

    // Randomized runs
    for (int r = 0; r < 24; r++) begin
      lw = $urandom_range(0, 5);
      hs = $urandom_range(0, 15);
      ms = (r % 3 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 4000);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, (1 << lw) - 1) : -1;
      n  = 1 << lw;
      if (r % 4 == 1) begin
        for (int k = 0; k < n; k++) data_q.push_back($urandom_range(0, 600) - 300);
      end
      for (int k = 0; k < n; k++) gap_q.push_back($urandom_range(0, 2));
      run_cal(lw, hs, ms, ab);
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
